dzmmu_responder: RTL and testbench

Memory-bus responder for the dzcpu master port. It decodes every CPU read and write on the 16-bit address bus, serves on-chip work RAM, high RAM, the boot ROM overlay and the interrupt registers IF/IE, and forwards everything else to one external peripheral/cartridge port. It sits between the CPU core and the rest of the GB memory map. It also returns one registered read byte per request.

---
 rtl/dzmmu_responder.sv | 126 ++++++++++++
 tb/tb_dzmmu_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dzmmu_responder.sv
// Memory-bus responder for the dzcpu master port: decodes CPU accesses, serves
// WRAM/HRAM/boot ROM/IF/IE locally and forwards everything else externally.
module dzmmu_responder #(
    parameter int unsigned WRAM_AW = 13,
    parameter int unsigned BOOT_AW = 8
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [15:0]        iMCUAddr,
    input  logic [7:0]         iMCUData,
    input  logic               iMCUwe,
    input  logic               iMcuReadRequest,
    output logic [7:0]         oMCUData,
    output logic [BOOT_AW-1:0] oBootAddr,
    input  logic [7:0]         iBootData,
    output logic [15:0]        oExtAddr,
    output logic [7:0]         oExtData,
    output logic               oExtWe,
    output logic               oExtRead,
    input  logic [7:0]         iExtData,
    input  logic [4:0]         iIntRequest,
    output logic [4:0]         oIE,
    output logic [4:0]         oIF,
    output logic               oBootActive
);

    localparam int unsigned WRAM_DEPTH = 1 << WRAM_AW;
    localparam int unsigned HRAM_AW    = 7;
    localparam int unsigned HRAM_DEPTH = 1 << HRAM_AW;

    logic [7:0] wram_mem [WRAM_DEPTH];
    logic [7:0] hram_mem [HRAM_DEPTH];

    logic [7:0] data_q, data_d;
    logic [4:0] ie_q, ie_d;
    logic [4:0] if_q, if_d;
    logic       boot_q, boot_d;

    logic boot_hit, wram_hit, unmap_hit, if_hit, ff50_hit, hram_hit, ie_hit;
    logic int_hit, ext_wr_sel, ext_rd_sel, rd_fire;
    logic [WRAM_AW-1:0] wram_idx;
    logic [HRAM_AW-1:0] hram_idx;
    logic [7:0]         rd_byte;

    // Address decode; boot-region writes fall through to the external port
    always_comb begin
        boot_hit   = (iMCUAddr[15:8] == 8'h00) && boot_q;
        wram_hit   = (iMCUAddr >= 16'hC000) && (iMCUAddr <= 16'hFDFF);
        unmap_hit  = (iMCUAddr >= 16'hFEA0) && (iMCUAddr <= 16'hFEFF);
        if_hit     = (iMCUAddr == 16'hFF0F);
        ff50_hit   = (iMCUAddr == 16'hFF50);
        ie_hit     = (iMCUAddr == 16'hFFFF);
        hram_hit   = (iMCUAddr[15:7] == 9'h1FF) && !ie_hit;
        int_hit    = wram_hit | unmap_hit | if_hit | ff50_hit | hram_hit | ie_hit;
        ext_wr_sel = !int_hit;
        ext_rd_sel = !int_hit && !boot_hit;
        rd_fire    = iMcuReadRequest && !iMCUwe;
        wram_idx   = iMCUAddr[WRAM_AW-1:0];
        hram_idx   = iMCUAddr[HRAM_AW-1:0];
    end

    assign oBootAddr   = iMCUAddr[BOOT_AW-1:0];
    assign oExtAddr    = iMCUAddr;
    assign oExtData    = iMCUData;
    assign oExtWe      = iMCUwe && ext_wr_sel;
    assign oExtRead    = rd_fire && ext_rd_sel;
    assign oMCUData    = data_q;
    assign oIE         = ie_q;
    assign oIF         = if_q;
    assign oBootActive = boot_q;

    // Read mux in decode priority order
    always_comb begin
        rd_byte = iExtData;
        if (boot_hit)       rd_byte = iBootData;
        else if (wram_hit)  rd_byte = wram_mem[wram_idx];
        else if (if_hit)    rd_byte = {3'b111, if_q};
        else if (ff50_hit)  rd_byte = {7'h7F, ~boot_q};
        else if (hram_hit)  rd_byte = hram_mem[hram_idx];
        else if (ie_hit)    rd_byte = {3'b000, ie_q};
        else if (unmap_hit) rd_byte = 8'hFF;
    end

    // Next-state for the control registers; interrupt requests beat CPU writes to IF
    always_comb begin
        data_d = data_q;
        ie_d   = ie_q;
        if_d   = if_q;
        boot_d = boot_q;
        if (rd_fire)
            data_d = rd_byte;
        if (iMCUwe && ie_hit)
            ie_d = iMCUData[4:0];
        if (iMCUwe && if_hit)
            if_d = iMCUData[4:0];
        if_d = if_d | iIntRequest;
        if (iMCUwe && ff50_hit && (iMCUData != 8'h00))
            boot_d = 1'b0;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            data_q <= 8'h00;
            ie_q   <= 5'h00;
            if_q   <= 5'h00;
            boot_q <= 1'b1;
        end else begin
            data_q <= data_d;
            ie_q   <= ie_d;
            if_q   <= if_d;
            boot_q <= boot_d;
        end
    end

    // RAM arrays carry no reset; writes are suppressed while reset is held
    always_ff @(posedge iClock or negedge iReset) begin
        if (iReset && iMCUwe && wram_hit)
            wram_mem[wram_idx] <= iMCUData;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (iReset && iMCUwe && hram_hit)
            hram_mem[hram_idx] <= iMCUData;
    end

endmodule

// File: tb/tb_dzmmu_responder.sv
// Directed self-checking bench for dzmmu_responder.
module tb_dzmmu_responder;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [15:0] iMCUAddr;
    logic [7:0]  iMCUData;
    logic        iMCUwe;
    logic        iMcuReadRequest;
    logic [7:0]  oMCUData;
    logic [7:0]  oBootAddr;
    logic [7:0]  iBootData;
    logic [15:0] oExtAddr;
    logic [7:0]  oExtData;
    logic        oExtWe;
    logic        oExtRead;
    logic [7:0]  iExtData;
    logic [4:0]  iIntRequest;
    logic [4:0]  oIE;
    logic [4:0]  oIF;
    logic        oBootActive;

    int errors = 0;
    int checks = 0;

    dzmmu_responder #(.WRAM_AW(13), .BOOT_AW(8)) dut (
        .iClock(iClock), .iReset(iReset), .iMCUAddr(iMCUAddr), .iMCUData(iMCUData),
        .iMCUwe(iMCUwe), .iMcuReadRequest(iMcuReadRequest), .oMCUData(oMCUData),
        .oBootAddr(oBootAddr), .iBootData(iBootData), .oExtAddr(oExtAddr),
        .oExtData(oExtData), .oExtWe(oExtWe), .oExtRead(oExtRead), .iExtData(iExtData),
        .iIntRequest(iIntRequest), .oIE(oIE), .oIF(oIF), .oBootActive(oBootActive)
    );

    always #5 iClock = ~iClock;

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge iClock);
        iMCUAddr = a; iMCUData = d; iMCUwe = 1'b1; iMcuReadRequest = 1'b0;
        @(posedge iClock); #1;
        iMCUwe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] q, output logic ext_rd);
        @(negedge iClock);
        iMCUAddr = a; iMCUwe = 1'b0; iMcuReadRequest = 1'b1;
        #1 ext_rd = oExtRead;
        @(posedge iClock); #1;
        q = oMCUData;
        iMcuReadRequest = 1'b0;
    endtask

    task automatic test_reset();
        iReset = 1'b0; iMCUAddr = 16'h0000; iMCUData = 8'h00; iMCUwe = 1'b0;
        iMcuReadRequest = 1'b0; iBootData = 8'h31; iExtData = 8'h00; iIntRequest = 5'h00;
        #12;
        checks++; if (oMCUData !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", oMCUData); end
        checks++; if (oIE !== 5'h00) begin errors++; $display("FAIL reset_ie got %h exp 00", oIE); end
        checks++; if (oIF !== 5'h00) begin errors++; $display("FAIL reset_if got %h exp 00", oIF); end
        checks++; if (oBootActive !== 1'b1) begin errors++; $display("FAIL reset_boot got %b exp 1", oBootActive); end
        @(negedge iClock); iReset = 1'b1;
    endtask

    task automatic test_boot_overlay();
        logic [7:0] q; logic er;
        bus_read(16'h0000, q, er);
        checks++; if (q !== 8'h31) begin errors++; $display("FAIL boot_read got %h exp 31", q); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL boot_extread got %b exp 0", er); end
        bus_write(16'hFF50, 8'h00);
        checks++; if (oBootActive !== 1'b1) begin errors++; $display("FAIL ff50_zero got %b exp 1", oBootActive); end
        bus_read(16'h0000, q, er);
        checks++; if (q !== 8'h31) begin errors++; $display("FAIL boot_still got %h exp 31", q); end
        bus_read(16'hFF50, q, er);
        checks++; if (q !== 8'hFE) begin errors++; $display("FAIL ff50_read_on got %h exp FE", q); end
        bus_write(16'hFF50, 8'h01);
        checks++; if (oBootActive !== 1'b0) begin errors++; $display("FAIL ff50_clear got %b exp 0", oBootActive); end
        iExtData = 8'hC3;
        bus_read(16'h0000, q, er);
        checks++; if (q !== 8'hC3) begin errors++; $display("FAIL post_boot_read got %h exp C3", q); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL post_boot_extread got %b exp 1", er); end
        bus_read(16'hFF50, q, er);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL ff50_read_off got %h exp FF", q); end
    endtask

    task automatic test_wram();
        logic [7:0] q; logic er;
        bus_write(16'hC123, 8'hA5);
        bus_read(16'hE123, q, er);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL echo_read got %h exp A5", q); end
        bus_write(16'hFDFF, 8'h5A);
        bus_read(16'hDDFF, q, er);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL echo_write got %h exp 5A", q); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wram_extread got %b exp 0", er); end
    endtask

    task automatic test_back_to_back();
        @(negedge iClock); iMCUAddr = 16'hC123; iMCUwe = 1'b0; iMcuReadRequest = 1'b1;
        @(posedge iClock); #1;
        checks++; if (oMCUData !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h exp A5", oMCUData); end
        @(negedge iClock); iMCUAddr = 16'hDDFF;
        @(posedge iClock); #1;
        checks++; if (oMCUData !== 8'h5A) begin errors++; $display("FAIL b2b_second got %h exp 5A", oMCUData); end
        iMcuReadRequest = 1'b0;
    endtask

    task automatic test_if_collision();
        logic [7:0] q; logic er;
        bus_write(16'hFF0F, 8'h01);
        checks++; if (oIF !== 5'b00001) begin errors++; $display("FAIL if_write got %b exp 00001", oIF); end
        @(negedge iClock);
        iMCUAddr = 16'hFF0F; iMCUData = 8'h00; iMCUwe = 1'b1; iIntRequest = 5'b00100;
        @(posedge iClock); #1;
        iMCUwe = 1'b0; iIntRequest = 5'b00000;
        checks++; if (oIF !== 5'b00100) begin errors++; $display("FAIL if_collision got %b exp 00100", oIF); end
        bus_read(16'hFF0F, q, er);
        checks++; if (q !== 8'hE4) begin errors++; $display("FAIL if_read got %h exp E4", q); end
    endtask

    task automatic test_ie_hram_unmapped();
        logic [7:0] q; logic er;
        bus_write(16'hFFFF, 8'hFF);
        checks++; if (oIE !== 5'h1F) begin errors++; $display("FAIL ie_write got %h exp 1F", oIE); end
        bus_read(16'hFFFF, q, er);
        checks++; if (q !== 8'h1F) begin errors++; $display("FAIL ie_read got %h exp 1F", q); end
        bus_write(16'hFF80, 8'h77);
        bus_read(16'hFF80, q, er);
        checks++; if (q !== 8'h77) begin errors++; $display("FAIL hram_read got %h exp 77", q); end
        bus_read(16'hFEA0, q, er);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL unmapped_read got %h exp FF", q); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL unmapped_extread got %b exp 0", er); end
    endtask

    task automatic test_external();
        logic [7:0] q; logic er;
        @(negedge iClock);
        iMCUAddr = 16'h2000; iMCUData = 8'h02; iMCUwe = 1'b1;
        #1;
        checks++; if (oExtWe !== 1'b1) begin errors++; $display("FAIL ext_we got %b exp 1", oExtWe); end
        checks++; if (oExtAddr !== 16'h2000) begin errors++; $display("FAIL ext_addr got %h exp 2000", oExtAddr); end
        checks++; if (oExtData !== 8'h02) begin errors++; $display("FAIL ext_data got %h exp 02", oExtData); end
        @(posedge iClock); #1;
        iMCUwe = 1'b0; #1;
        checks++; if (oExtWe !== 1'b0) begin errors++; $display("FAIL ext_we_drop got %b exp 0", oExtWe); end
        checks++; if (oIE !== 5'h1F || oIF !== 5'b00100 || oMCUData !== 8'hFF)
            begin errors++; $display("FAIL ext_no_side got ie=%h if=%b data=%h exp ie=1F if=00100 data=FF", oIE, oIF, oMCUData); end
        iExtData = 8'h9C;
        bus_read(16'h3000, q, er);
        checks++; if (q !== 8'h9C) begin errors++; $display("FAIL ext_read got %h exp 9C", q); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL ext_read_strobe got %b exp 1", er); end
        // simultaneous write and read: write lands, read data untouched
        @(negedge iClock);
        iMCUAddr = 16'hC123; iMCUData = 8'h11; iMCUwe = 1'b1; iMcuReadRequest = 1'b1;
        #1;
        checks++; if (oExtRead !== 1'b0) begin errors++; $display("FAIL wr_rd_extread got %b exp 0", oExtRead); end
        @(posedge iClock); #1;
        iMCUwe = 1'b0; iMcuReadRequest = 1'b0;
        checks++; if (oMCUData !== 8'h9C) begin errors++; $display("FAIL wr_rd_hold got %h exp 9C", oMCUData); end
        bus_read(16'hC123, q, er);
        checks++; if (q !== 8'h11) begin errors++; $display("FAIL wr_rd_write got %h exp 11", q); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q; logic er;
        @(negedge iClock);
        iMCUAddr = 16'hFFFF; iMCUData = 8'h00; iMCUwe = 1'b1;
        #2 iReset = 1'b0;
        #1;
        checks++; if (oIE !== 5'h00) begin errors++; $display("FAIL mid_reset_ie got %h exp 00", oIE); end
        checks++; if (oIF !== 5'h00) begin errors++; $display("FAIL mid_reset_if got %h exp 00", oIF); end
        checks++; if (oBootActive !== 1'b1) begin errors++; $display("FAIL mid_reset_boot got %b exp 1", oBootActive); end
        checks++; if (oMCUData !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h exp 00", oMCUData); end
        iMCUAddr = 16'hC123; iMCUData = 8'h99;
        @(posedge iClock); #1;
        @(negedge iClock); iMCUwe = 1'b0; iReset = 1'b1;
        bus_read(16'hC123, q, er);
        checks++; if (q !== 8'h11) begin errors++; $display("FAIL reset_ram_guard got %h exp 11", q); end
        bus_read(16'h0000, q, er);
        checks++; if (q !== 8'h31) begin errors++; $display("FAIL reset_boot_restored got %h exp 31", q); end
    endtask

    initial begin
        test_reset();
        test_boot_overlay();
        test_wram();
        test_back_to_back();
        test_if_collision();
        test_ie_hram_unmapped();
        test_external();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
